// File: rtl/pipe_pkg.sv
// ============================================================
// pipe_pkg: shared types for pipeline sequencing control. Rev 1.0
// ============================================================
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                 idex_we: 1'b1, idex_flush: 1'b0, exmem_we: 1'b1};
  localparam ctrl_t CTRL_RESET = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b1,
                                   idex_we: 1'b0, idex_flush: 1'b1, exmem_we: 1'b0};
  localparam ctrl_t CTRL_HOLD = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                  idex_we: 1'b0, idex_flush: 1'b0, exmem_we: 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                   idex_we: 1'b1, idex_flush: 1'b1, exmem_we: 1'b1};
  // Bubble: PC and IF/ID hold, ID/EX loads a cleared slot.
  localparam ctrl_t CTRL_BUBBLE = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                    idex_we: 1'b1, idex_flush: 1'b1, exmem_we: 1'b1};

  function automatic logic src_hits(input logic used, input logic [4:0] src,
                                    input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================
// sat_counter: up-counter that sticks at all-ones. Rev 1.0
// ============================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_MAX = '1;

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================
// hazard_ctrl: load-use, branch-flush and memory-freeze sequencing. Rev 1.0
// ============================================================
`default_nettype none

module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int BR_EXTRA    = 0,
  parameter int CNT_W       = 16
) (
  input  logic             reloj,
  input  logic             resetn,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             mem_read_exe,
  input  logic [4:0]       rt_exe,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] C_TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);
  localparam logic [1:0] C_BR_EXTRA   = 2'(BR_EXTRA);
  localparam bit         C_HAS_EXTRA  = (BR_EXTRA > 0);

  state_t      r_state;
  logic [7:0]  r_wait_cnt;
  logic [1:0]  r_flush_cnt;

  logic        w_load_use;
  ctrl_t       w_ctrl;
  logic        w_stall_inc;

  assign w_load_use = mem_read_exe && (rt_exe != REG_ZERO) &&
                      (src_hits(uses_rs, rs_id, rt_exe) || src_hits(uses_rt, rt_id, rt_exe));

  // A releasing MEM_WAIT falls through to the RUN rules below.
  always_comb begin
    w_ctrl = CTRL_RUN;
    if (!resetn) begin
      w_ctrl = CTRL_RESET;
    end else if (r_state == ERR) begin
      w_ctrl = CTRL_HOLD;
    end else if (mem_busy) begin
      w_ctrl = CTRL_HOLD;
    end else if (branch_taken || (r_state == FLUSH)) begin
      w_ctrl = CTRL_FLUSH;
    end else if (w_load_use) begin
      w_ctrl = CTRL_BUBBLE;
    end
  end

  assign pc_we      = w_ctrl.pc_we;
  assign ifid_we    = w_ctrl.ifid_we;
  assign ifid_flush = w_ctrl.ifid_flush;
  assign idex_we    = w_ctrl.idex_we;
  assign idex_flush = w_ctrl.idex_flush;
  assign exmem_we   = w_ctrl.exmem_we;
  assign mem_err    = resetn && (r_state == ERR);

  always_ff @(posedge reloj or negedge resetn) begin
    if (!resetn) begin
      r_state     <= RUN;
      r_wait_cnt  <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != ERR) begin
      if (mem_busy) begin
        // The wait count is zero outside MEM_WAIT, so this also covers MEM_TIMEOUT=1.
        r_state    <= (r_wait_cnt == C_TIMEOUT_M1) ? ERR : MEM_WAIT;
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
        if (branch_taken) begin
          if (C_HAS_EXTRA) begin
            r_state     <= FLUSH;
            r_flush_cnt <= C_BR_EXTRA;
          end else begin
            r_state <= RUN;
          end
        end else if ((r_state == FLUSH) && (r_flush_cnt > 2'd1)) begin
          r_flush_cnt <= r_flush_cnt - 2'd1;
        end else begin
          r_state <= RUN;
        end
      end
    end
  end

  assign w_stall_inc = resetn && !w_ctrl.pc_we && (r_state != ERR);

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (reloj),
    .rst_n (resetn),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

endmodule

`default_nettype wire
